// File: rtl/btn_sel_pkg.sv
// Shared types and defaults for the button/select input conditioner.
// Default reset values and timing constants live here.
package btn_sel_pkg;

   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int SCAN_CYCLES_DEF     = 50000000;

   localparam sel_t SEL_RESET = '0;

   function automatic sel_t sel_step(input sel_t s);
      return s + sel_t'(1);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One raw input: 2-FF synchroniser, debounce counter, rising pulse.
// The pulse is registered so it lines up with the first high level.
module debounce_cell
   import btn_sel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_stable;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;

   logic w_diff;
   logic w_done;

   assign w_diff = r_sync ^ r_stable;
   assign w_done = w_diff && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_stable <= 1'b0;
         r_pulse  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_meta  <= i_raw;
         r_sync  <= r_meta;
         r_pulse <= w_done & r_sync;
         if (!w_diff || w_done)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CW'(1);
         if (w_done)
            r_stable <= r_sync;
      end
   end

   assign o_level = r_stable;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_sel_cond.sv
// Button/switch conditioner and 2-bit mux select register.
// Define AUTO_SCAN_EN to add a periodic select auto-advance.
module btn_sel_cond
   import btn_sel_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef AUTO_SCAN_EN
   ,
   parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF
`endif
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [N_BTN-1:0] iBTN,
   input  logic             iBTN_NEXT,
   input  logic             iBTN_LOAD,
   input  logic [1:0]       iSEL_SW,
   output logic [N_BTN-1:0] oBTN,
   output logic [N_BTN-1:0] oBTN_PULSE,
   output logic [1:0]       oSEL
);

   localparam int NC = N_BTN + 2;

   logic [NC-1:0] w_raw;
   logic [NC-1:0] w_lvl;
   logic [NC-1:0] w_pls;
   logic          w_next;
   logic          w_load;

   sel_t r_sw_meta;
   sel_t r_sw_sync;
   sel_t r_sel;

   assign w_raw = {iBTN_LOAD, iBTN_NEXT, iBTN};

   for (genvar g = 0; g < NC; g++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .i_clk  (iCLK),
         .i_rst  (iRST),
         .i_raw  (w_raw[g]),
         .o_level(w_lvl[g]),
         .o_pulse(w_pls[g])
      );
   end

   // A pulse always coincides with a high level; the AND keeps both used.
   assign w_next = w_pls[N_BTN]     & w_lvl[N_BTN];
   assign w_load = w_pls[N_BTN + 1] & w_lvl[N_BTN + 1];

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_sw_meta <= SEL_RESET;
         r_sw_sync <= SEL_RESET;
      end else begin
         r_sw_meta <= iSEL_SW;
         r_sw_sync <= r_sw_meta;
      end
   end

`ifdef AUTO_SCAN_EN
   localparam int SW = $clog2(SCAN_CYCLES);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

   logic [SW-1:0] r_scan;
   logic          w_scan;

   assign w_scan = (r_scan == SCAN_LAST);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         r_scan <= '0;
      else if (w_load || w_next || w_scan)
         r_scan <= '0;
      else
         r_scan <= r_scan + SW'(1);
   end
`endif

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         r_sel <= SEL_RESET;
      else if (w_load)
         r_sel <= r_sw_sync;
      else if (w_next)
         r_sel <= sel_step(r_sel);
`ifdef AUTO_SCAN_EN
      else if (w_scan)
         r_sel <= sel_step(r_sel);
`endif
   end

   assign oBTN       = w_lvl[N_BTN-1:0];
   assign oBTN_PULSE = w_pls[N_BTN-1:0];
   assign oSEL       = r_sel;

endmodule

// File: tb/tb_btn_sel_cond.sv
// Directed and random checks of btn_sel_cond against a window model.
// Build with AUTO_SCAN_EN to also cover the auto-scan feature.
module tb_btn_sel_cond;

   localparam int NB = 4;
   localparam int D  = 4;
   localparam int SC = 16;
   localparam int NC = NB + 2;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b1;
   logic [NB-1:0] iBTN = '0;
   logic          iBTN_NEXT = 1'b0;
   logic          iBTN_LOAD = 1'b0;
   logic [1:0]    iSEL_SW = '0;
   logic [NB-1:0] oBTN;
   logic [NB-1:0] oBTN_PULSE;
   logic [1:0]    oSEL;

   int checks = 0;
   int errors = 0;

   btn_sel_cond #(
      .N_BTN(NB),
      .DEBOUNCE_CYCLES(D)
`ifdef AUTO_SCAN_EN
      ,
      .SCAN_CYCLES(SC)
`endif
   ) dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iBTN      (iBTN),
      .iBTN_NEXT (iBTN_NEXT),
      .iBTN_LOAD (iBTN_LOAD),
      .iSEL_SW   (iSEL_SW),
      .oBTN      (oBTN),
      .oBTN_PULSE(oBTN_PULSE),
      .oSEL      (oSEL)
   );

   always #5 iCLK = ~iCLK;

   // Model: raw-sample history; a bit flips once the D newest
   // synchronised samples all disagree with its stable value.
   logic [NC-1:0] m_h [0:D+1];
   logic [1:0]    m_swh [0:2];
   logic [NC-1:0] m_st;
   logic [NC-1:0] m_pls;
   logic [1:0]    m_sel;
   int            m_k;
   int            m_anchor;

   task automatic model_reset();
      for (int j = 0; j <= D + 1; j++) m_h[j] = '0;
      for (int j = 0; j < 3; j++) m_swh[j] = '0;
      m_st = '0;
      m_pls = '0;
      m_sel = '0;
      m_k = 0;
      m_anchor = 0;
   endtask

   task automatic model_edge(input logic [NC-1:0] raw,
                             input logic [1:0] sw);
      logic [NC-1:0] acc;
      for (int j = D + 1; j > 0; j--) m_h[j] = m_h[j-1];
      m_h[0] = raw;
      m_swh[2] = m_swh[1];
      m_swh[1] = m_swh[0];
      m_swh[0] = sw;
      m_k++;
      if (m_pls[NB+1])
         m_sel = m_swh[2];
      else if (m_pls[NB])
         m_sel = m_sel + 2'd1;
`ifdef AUTO_SCAN_EN
      else if ((m_k - m_anchor) % SC == 0)
         m_sel = m_sel + 2'd1;
      if (m_pls[NB+1] || m_pls[NB])
         m_anchor = m_k;
`endif
      for (int b = 0; b < NC; b++) begin
         acc[b] = 1'b1;
         for (int j = 2; j <= D + 1; j++)
            if (m_h[j][b] == m_st[b]) acc[b] = 1'b0;
      end
      m_pls = acc & ~m_st;
      m_st = m_st ^ acc;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("model_btn", int'(oBTN), int'(m_st[NB-1:0]));
      chk("model_pulse", int'(oBTN_PULSE), int'(m_pls[NB-1:0]));
      chk("model_sel", int'(oSEL), int'(m_sel));
   endtask

   task automatic tick();
      logic [NC-1:0] raw;
      logic [1:0]    sw;
      logic          rs;
      raw = {iBTN_LOAD, iBTN_NEXT, iBTN};
      sw = iSEL_SW;
      rs = iRST;
      @(posedge iCLK);
      #1;
      if (!rs) model_edge(raw, sw);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int n);
      iRST = 1'b1;
      #1;
      model_reset();
      chk("rst_btn", int'(oBTN), 0);
      chk("rst_pulse", int'(oBTN_PULSE), 0);
      chk("rst_sel", int'(oSEL), 0);
      ticks(n);
      iRST = 1'b0;
   endtask

   initial begin
      int lat;
      int npl;
      int seen;
      int t1;
      int t2;
      logic [1:0] s0;
      logic [1:0] s1;
      model_reset();
      @(posedge iCLK);
      #1;
      do_reset(2);

      // 1: idle after reset
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | int'(oBTN) | int'(oBTN_PULSE);
`ifndef AUTO_SCAN_EN
         seen = seen | int'(oSEL);
`endif
      end
      chk("idle_zero", seen, 0);

      // 2: glitch rejected, then a real press
      iBTN[2] = 1'b1;
      ticks(3);
      iBTN[2] = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | int'(oBTN) | int'(oBTN_PULSE);
      end
      chk("glitch", seen, 0);
      iBTN[2] = 1'b1;
      lat = 0;
      npl = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 10) iBTN[2] = 1'b0;
         npl += int'(oBTN_PULSE[2]);
         if (oBTN[2] && lat == 0) begin
            lat = i;
            chk("pulse_at_rise", int'(oBTN_PULSE[2]), 1);
         end
      end
      chk("latency", lat, 6);
      chk("pulse_count", npl, 1);

      // 3: NEXT steps the select
      for (int p = 0; p < 4; p++) begin
         iBTN_NEXT = 1'b1;
         ticks(10);
         iBTN_NEXT = 1'b0;
         ticks(10);
`ifndef AUTO_SCAN_EN
         chk("next_step", int'(oSEL), (p + 1) % 4);
`endif
      end

      // 4: LOAD, and LOAD beating NEXT
      iSEL_SW = 2'b10;
      ticks(4);
      iBTN_LOAD = 1'b1;
      ticks(10);
      iBTN_LOAD = 1'b0;
      ticks(10);
`ifndef AUTO_SCAN_EN
      chk("load", int'(oSEL), 2);
`endif
      iSEL_SW = 2'b01;
      ticks(4);
      iBTN_NEXT = 1'b1;
      iBTN_LOAD = 1'b1;
      ticks(10);
      iBTN_NEXT = 1'b0;
      iBTN_LOAD = 1'b0;
      ticks(10);
`ifndef AUTO_SCAN_EN
      chk("load_wins", int'(oSEL), 1);
`endif

      // 5: reset mid-debounce, button held through release
      iBTN[0] = 1'b1;
      ticks(4);
      do_reset(1);
      lat = 0;
      npl = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         npl += int'(oBTN_PULSE[0]);
         if (oBTN_PULSE[0] && lat == 0) lat = i;
      end
      chk("post_rst_lat", lat, 6);
      chk("post_rst_pulses", npl, 1);
      iBTN[0] = 1'b0;
      ticks(10);

      // random traffic against the model
      for (int r = 0; r < 300; r++) begin
         iBTN = NB'($urandom);
         iBTN_NEXT = 1'($urandom_range(0, 3) == 0);
         iBTN_LOAD = 1'($urandom_range(0, 4) == 0);
         iSEL_SW = 2'($urandom);
         ticks($urandom_range(1, 8));
      end
      iBTN = '0;
      iBTN_NEXT = 1'b0;
      iBTN_LOAD = 1'b0;
      ticks(12);

`ifdef AUTO_SCAN_EN
      // 6: periodic scan and restart on NEXT
      do_reset(1);
      for (int t = 1; t <= 4 * SC; t++) begin
         tick();
         if (t % SC == 0) chk("scan_step", int'(oSEL), (t / SC) % 4);
      end
      ticks(4);
      s0 = oSEL;
      s1 = oSEL;
      t1 = 0;
      t2 = 0;
      iBTN_NEXT = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 10) iBTN_NEXT = 1'b0;
         if (oSEL != s1) begin
            if (t1 == 0) t1 = i;
            else if (t2 == 0) t2 = i;
            s1 = oSEL;
            if (t2 == 0) chk("scan_next", int'(oSEL), int'(s0) + 1);
         end
      end
      chk("scan_restart", t2 - t1, SC);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
